// File: rtl/cam_update_ctrl.sv
// rtl/cam_update_ctrl.sv - write-side controller for a bank of cam_cmp_lutram entries
// Keeps a shadow copy of every entry's key/valid so target selection needs no CAM read-back.
module cam_update_ctrl #(
    parameter int ENTRIES         = 8,
    parameter int PACKS_OF_5_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [PACKS_OF_5_BITS-1:0][4:0]      req_key_i,
    input  logic                                 req_inv_i,
    input  logic                                 flush_i,
    output logic [ENTRIES-1:0]                   upd_o,
    output logic [PACKS_OF_5_BITS-1:0][4:0]      set_key_o,
    output logic                                 set_key_valid_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [$clog2(ENTRIES)-1:0]           done_idx_o,
    output logic                                 done_hit_o
);
    localparam int IW    = $clog2(ENTRIES);
    localparam int KEY_W = 5 * PACKS_OF_5_BITS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] FLUSH  = 2'd3;

    localparam logic [ENTRIES-1:0] ONE = 1;
    localparam logic [IW-1:0]      LAST_IDX = IW'(ENTRIES - 1);

    logic [1:0]         state_q;
    logic [IW-1:0]      fidx_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      tgt_q;
    logic [ENTRIES-1:0] valid_q;
    logic [KEY_W-1:0]   key_q [ENTRIES];
    logic [KEY_W-1:0]   rkey_q;
    logic               rinv_q;
    logic               rhit_q;
    logic               fl_q;
    logic               done_q;
    logic [IW-1:0]      done_idx_q;
    logic               done_hit_q;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               free;
    logic [IW-1:0]      free_idx;
    logic               accept;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == req_key_i)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign req_ready_o     = (state_q == IDLE) && !flush_i;
    assign accept          = req_valid_i && req_ready_o;
    assign busy_o          = (state_q != IDLE);
    assign upd_o           = (state_q == ISSUE) ? (ONE << tgt_q) :
                             (state_q == FLUSH) ? (ONE << fidx_q) : '0;
    assign set_key_o       = (state_q == ISSUE) ? rkey_q : '0;
    assign set_key_valid_o = (state_q == ISSUE) && !rinv_q;
    assign done_o          = done_q;
    assign done_idx_o      = done_idx_q;
    assign done_hit_o      = done_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FLUSH;
            fidx_q     <= '0;
            ptr_q      <= '0;
            tgt_q      <= '0;
            valid_q    <= '0;
            rkey_q     <= '0;
            rinv_q     <= 1'b0;
            rhit_q     <= 1'b0;
            fl_q       <= 1'b1;
            done_q     <= 1'b0;
            done_idx_q <= '0;
            done_hit_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_idx_q <= '0;
            done_hit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q <= FLUSH;
                        fidx_q  <= '0;
                        ptr_q   <= '0;
                        valid_q <= '0;
                        fl_q    <= 1'b1;
                    end else if (accept) begin
                        if (req_inv_i && !hit) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            fl_q    <= 1'b0;
                            rkey_q  <= req_key_i;
                            rinv_q  <= req_inv_i;
                            rhit_q  <= hit;
                            if (hit) begin
                                tgt_q <= hit_idx;
                            end else if (free) begin
                                tgt_q <= free_idx;
                            end else begin
                                tgt_q <= ptr_q;
                                ptr_q <= ptr_q + IW'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    valid_q[tgt_q] <= !rinv_q;
                    state_q        <= SETTLE;
                end
                SETTLE: begin
                    state_q <= IDLE;
                    if (!fl_q) begin
                        done_q     <= 1'b1;
                        done_idx_q <= tgt_q;
                        done_hit_q <= rhit_q;
                    end
                end
                default: begin
                    if (fidx_q == LAST_IDX) begin
                        state_q <= SETTLE;
                    end else begin
                        fidx_q <= fidx_q + IW'(1);
                    end
                end
            endcase
        end
    end

    // Shadow keys are only meaningful under valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ISSUE) begin
            key_q[tgt_q] <= rkey_q;
        end
    end
endmodule

// File: tb/tb_cam_update_ctrl.sv
// tb/tb_cam_update_ctrl.sv - scoreboard bench for cam_update_ctrl
module tb_cam_update_ctrl;
    localparam int ENTRIES = 8;
    localparam int P       = 4;
    localparam int KW      = 5 * P;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_inv = 1'b0;
    logic              flush = 1'b0;
    logic [P-1:0][4:0] req_key = '0;
    logic              req_ready;
    logic [ENTRIES-1:0] upd;
    logic [P-1:0][4:0] set_key;
    logic              skv;
    logic              busy;
    logic              done;
    logic [2:0]        done_idx;
    logic              done_hit;

    cam_update_ctrl #(.ENTRIES(ENTRIES), .PACKS_OF_5_BITS(P)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_key_i(req_key),
        .req_inv_i(req_inv), .flush_i(flush),
        .upd_o(upd), .set_key_o(set_key), .set_key_valid_o(skv),
        .busy_o(busy), .done_o(done), .done_idx_o(done_idx), .done_hit_o(done_hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            idx;
        bit            hit;
        logic [KW-1:0] lkey;
        bit            lhit;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [KW-1:0] m_key[ENTRIES];
    bit            m_valid[ENTRIES];
    int            m_ptr = 0;
    logic [KW-1:0] cm_key[ENTRIES];
    bit            cm_valid[ENTRIES];
    int            done_cnt = 0;
    int            li;

    function automatic int cm_lookup(input logic [KW-1:0] k);
        for (int i = 0; i < ENTRIES; i++)
            if (cm_valid[i] && cm_key[i] == k) return i;
        return -1;
    endfunction

    // Model CAM entries follow the write strobes; done responses are scored against the queue.
    always @(negedge clk) begin
        if (upd != '0) check("upd_onehot", $countones(upd), 1);
        for (int i = 0; i < ENTRIES; i++)
            if (upd[i]) begin
                cm_key[i]   = set_key;
                cm_valid[i] = skv;
            end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_idx", done_idx, e.idx);
                check("done_hit", done_hit, e.hit);
                li = cm_lookup(e.lkey);
                check("lookup_hit", li >= 0, e.lhit);
                if (e.lhit) check("lookup_idx", li, e.idx);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_req(input logic [KW-1:0] k, input bit inv);
        int h = -1;
        int f = -1;
        int t;
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && m_key[i] == k && h < 0) h = i;
            if (!m_valid[i] && f < 0) f = i;
        end
        if (inv) begin
            if (h >= 0) begin
                m_valid[h] = 1'b0;
                sb.push_back('{h, 1'b1, k, 1'b0});
            end else begin
                sb.push_back('{0, 1'b0, k, 1'b0});
            end
        end else if (h >= 0) begin
            sb.push_back('{h, 1'b1, k, 1'b1});
        end else begin
            if (f >= 0) t = f;
            else begin
                t = m_ptr;
                m_ptr = (m_ptr + 1) % ENTRIES;
            end
            m_key[t]   = k;
            m_valid[t] = 1'b1;
            sb.push_back('{t, 1'b0, k, 1'b1});
        end
    endtask

    // Returns 1ns after the accepting edge, i.e. inside cycle t+1.
    task automatic do_req(input logic [KW-1:0] k, input bit inv);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        model_req(k, inv);
        req_valid = 1'b1;
        req_key   = k;
        req_inv   = inv;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
        #2;
    endtask

    // Starts at the first negedge where the FLUSH state is visible.
    task automatic flush_sweep();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                check("flush_upd", upd, 32'(1) << i);
                check("flush_busy", busy, 1);
                check("flush_skv", skv, 0);
            end else if (i == 8) begin
                check("settle_upd", upd, 0);
                check("settle_busy", busy, 1);
            end else begin
                check("post_flush_busy", busy, 0);
                check("post_flush_ready", req_ready, 1);
            end
            check("flush_no_done", done, 0);
            if (i < 9) @(negedge clk);
        end
    endtask

    logic [KW-1:0] fill_keys [8];
    int            d0;

    initial begin
        fill_keys[0] = 20'h12345; fill_keys[1] = 20'h11111;
        fill_keys[2] = 20'h22222; fill_keys[3] = 20'h00abc;
        fill_keys[4] = 20'h44444; fill_keys[5] = 20'h55555;
        fill_keys[6] = 20'h66666; fill_keys[7] = 20'h77777;
        for (int i = 0; i < ENTRIES; i++) cm_valid[i] = 1'b0;
        model_clear();

        // reset and power-up flush
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", req_ready, 0);
        flush_sweep();

        // first insert: write timing and done latency
        do_req(fill_keys[0], 1'b0);
        check("ins_upd", upd, 32'h01);
        check("ins_skv", skv, 1);
        check("ins_key", set_key, fill_keys[0]);
        check("ins_busy", busy, 1);
        @(posedge clk); #1;
        check("settle_upd0", upd, 0);
        check("settle_done0", done, 0);
        @(posedge clk); #1;
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        wait_idle();

        // fill, then two evictions through the victim pointer
        for (int i = 1; i < 8; i++) do_req(fill_keys[i], 1'b0);
        do_req(20'h99999, 1'b0);
        check("evict_upd", upd, 32'h01);
        do_req(20'haaaaa, 1'b0);
        check("evict2_upd", upd, 32'h02);
        wait_idle();
        check("evicted0_miss", cm_lookup(20'h12345), -1);
        check("evicted1_miss", cm_lookup(20'h11111), -1);

        // insert of a present key rewrites only its own entry
        do_req(20'h00abc, 1'b0);
        check("rehit_upd", upd, 32'h08);
        @(posedge clk); #1;
        check("rehit_settle_upd", upd, 0);
        wait_idle();

        // invalidate present, invalidate absent, refill lowest free
        do_req(20'h55555, 1'b1);
        check("inv_upd", upd, 32'h20);
        check("inv_skv", skv, 0);
        wait_idle();
        do_req(20'h3abcd, 1'b1);
        check("invmiss_done", done, 1);
        check("invmiss_upd", upd, 0);
        check("invmiss_busy", busy, 0);
        wait_idle();
        do_req(20'h0beef, 1'b0);
        check("refill_upd", upd, 32'h20);
        wait_idle();

        // reset during SETTLE
        do_req(20'h13579, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_upd", upd, 0);
        rst = 1'b1;
        sb.delete();
        model_clear();
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        flush_sweep();
        check("rst_no_done", done_cnt, d0);
        do_req(20'h00abc, 1'b0);
        check("post_rst_upd", upd, 32'h01);
        wait_idle();

        // flush beats a same-cycle request, which is accepted afterwards
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_key   = 20'h00abc;
        req_inv   = 1'b0;
        #1 check("flush_blocks_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        model_req(20'h00abc, 1'b0);
        flush_sweep();
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("after_flush_upd", upd, 32'h01);
        wait_idle();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
